// File: rtl/mac_accumulator.sv
// Block accumulator behind the Wallace multiplier: sums a programmable number of
// products into a wide accumulator and hands the block sum over a valid/ready port.
module mac_accumulator #(
    parameter int PW = 65,
    parameter int AW = 72,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] prod_in,
    input  logic          prod_valid,
    output logic          prod_ready,
    input  logic [LW-1:0] blk_len,
    input  logic          flush,
    output logic [AW-1:0] acc_out,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic          ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] acc_reg, acc_next;
    logic [LW:0]   cnt_reg, cnt_next;
    logic [LW:0]   len_reg, len_next;
    logic          ovf_reg, ovf_next;

    logic          accept;
    logic [AW:0]   sum;
    logic [LW:0]   cnt_inc;
    logic [LW:0]   len_first;

    // Handshake outputs come straight from the state register.
    assign prod_ready = (state_reg != HOLD);
    assign acc_valid  = (state_reg == HOLD);
    assign acc_out    = acc_reg;
    assign ovf        = ovf_reg;

    assign accept    = prod_valid & prod_ready;
    assign sum       = {1'b0, acc_reg} + {{(AW + 1 - PW){1'b0}}, prod_in};
    assign cnt_inc   = cnt_reg + (LW + 1)'(1);
    // A zero length field encodes the largest block, 2^LW products.
    assign len_first = (blk_len == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, blk_len};

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (flush) begin
                    acc_next = '0;
                    cnt_next = '0;
                    ovf_next = 1'b0;
                end else if (accept) begin
                    acc_next   = {{(AW - PW){1'b0}}, prod_in};
                    cnt_next   = (LW + 1)'(1);
                    len_next   = len_first;
                    ovf_next   = 1'b0;
                    state_next = (len_first == (LW + 1)'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (flush) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = IDLE;
                end else if (accept) begin
                    acc_next   = sum[AW-1:0];
                    ovf_next   = ovf_reg | sum[AW];
                    cnt_next   = cnt_inc;
                    state_next = (cnt_inc == len_reg) ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                // A completed result is never discarded, so flush is ignored here.
                if (acc_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
            ovf_reg   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed and randomized checks of mac_accumulator against an arithmetic block-sum model.
module tb_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic [64:0] prod_in;
    logic        prod_valid;
    logic        prod_ready;
    logic [7:0]  blk_len;
    logic        flush;
    logic [71:0] acc_out;
    logic        acc_valid;
    logic        acc_ready;
    logic        ovf;

    int n_total = 0;
    int n_bad   = 0;
    logic [64:0] pq[$];

    mac_accumulator #(.PW(65), .AW(72), .LW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .blk_len    (blk_len),
        .flush      (flush),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [64:0] rand_prod();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[64:0];
    endfunction

    // Presents every product in pq as one block; the expected result is the plain
    // integer sum of the products, reduced modulo 2^72, with ovf set if it exceeded 2^72.
    task automatic send_block(input logic [7:0] bl_first, input logic [7:0] bl_rest,
                              input bit gap, input int hold_cycles, input bit expect_done);
        logic [80:0] total;
        int n;
        total = '0;
        n = pq.size();
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                prod_valid = 1'b0;
                prod_in    = rand_prod();
                blk_len    = 8'($urandom);
                step();
                chk("gap_valid", 80'(acc_valid), 80'(0));
            end
            prod_valid = 1'b1;
            prod_in    = pq[i];
            blk_len    = (i == 0) ? bl_first : bl_rest;
            total      = total + 81'(pq[i]);
            step();
            if (i < n - 1 || !expect_done) begin
                chk("mid_valid", 80'(acc_valid), 80'(0));
                chk("mid_ready", 80'(prod_ready), 80'(1));
            end
        end
        prod_valid = 1'b0;
        if (expect_done) begin
            chk("done_valid", 80'(acc_valid), 80'(1));
            chk("done_sum", 80'(acc_out), 80'(total[71:0]));
            chk("done_ovf", 80'(ovf), 80'(total[80:72] != '0));
            chk("done_ready", 80'(prod_ready), 80'(0));
            acc_ready  = 1'b0;
            flush      = 1'b1;
            prod_valid = 1'b1;
            prod_in    = rand_prod();
            for (int h = 0; h < hold_cycles; h++) begin
                step();
                chk("hold_valid", 80'(acc_valid), 80'(1));
                chk("hold_sum", 80'(acc_out), 80'(total[71:0]));
                chk("hold_ovf", 80'(ovf), 80'(total[80:72] != '0));
                chk("hold_ready", 80'(prod_ready), 80'(0));
            end
            flush      = 1'b0;
            prod_valid = 1'b0;
            acc_ready  = 1'b1;
            step();
            acc_ready = 1'b0;
            chk("deliver_valid", 80'(acc_valid), 80'(0));
            chk("deliver_ready", 80'(prod_ready), 80'(1));
        end
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        prod_in    = 65'd123;
        prod_valid = 1'b1;
        blk_len    = 8'd1;
        flush      = 1'b0;
        acc_ready  = 1'b0;

        // Reset held for 3 edges with a valid product present.
        repeat (3) step();
        chk("rst_acc", 80'(acc_out), 80'(0));
        chk("rst_valid", 80'(acc_valid), 80'(0));
        chk("rst_ovf", 80'(ovf), 80'(0));
        chk("rst_ready", 80'(prod_ready), 80'(1));
        rst_n      = 1'b1;
        prod_valid = 1'b0;
        step();
        chk("idle_valid", 80'(acc_valid), 80'(0));

        // Single product.
        pq = '{65'd1024};
        send_block(8'd1, 8'd1, 1'b0, 0, 1'b1);

        // Block of 4 with gapped valids and 5 cycles of back-pressure.
        pq = '{65'd1024, 65'd2051, 65'd2050, 65'd4100};
        send_block(8'd4, 8'd4, 1'b1, 5, 1'b1);

        // 256 maximal products: forces wrap and sticky ovf.
        pq.delete();
        for (int i = 0; i < 256; i++) pq.push_back({65{1'b1}});
        send_block(8'd0, 8'd0, 1'b0, 2, 1'b1);

        // Next block starts with ovf cleared.
        pq = '{65'd5};
        send_block(8'd1, 8'd1, 1'b0, 1, 1'b1);

        // Flush with a simultaneous valid product drops the block.
        pq = '{65'd11, 65'd22, 65'd33};
        send_block(8'd4, 8'd4, 1'b0, 0, 1'b0);
        prod_valid = 1'b1;
        prod_in    = 65'd99;
        flush      = 1'b1;
        step();
        flush      = 1'b0;
        prod_valid = 1'b0;
        chk("flush_valid", 80'(acc_valid), 80'(0));
        chk("flush_ready", 80'(prod_ready), 80'(1));
        step();
        chk("flush_idle", 80'(acc_valid), 80'(0));
        pq = '{65'd7, 65'd8};
        send_block(8'd2, 8'd2, 1'b0, 0, 1'b1);

        // Length field changed after the first accept has no effect.
        pq = '{65'd100, 65'd200, 65'd300};
        send_block(8'd3, 8'd1, 1'b0, 1, 1'b1);

        // Reset mid-block discards the partial sum.
        pq = '{65'd500, 65'd600};
        send_block(8'd4, 8'd4, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_acc", 80'(acc_out), 80'(0));
        chk("midrst_valid", 80'(acc_valid), 80'(0));
        pq = '{65'd42};
        send_block(8'd1, 8'd1, 1'b0, 0, 1'b1);

        // Randomized blocks.
        for (int b = 0; b < 24; b++) begin
            n = (b == 23) ? 256 : int'($urandom_range(1, 16));
            pq.delete();
            for (int i = 0; i < n; i++) pq.push_back(rand_prod());
            send_block(8'(n), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
